sram_rd_ctrl: RTL



---
 rtl/sram_pkg.sv | 24 ++
 rtl/sram_rd_ctrl.sv | 129 ++++++++++++
 2 files changed

// File: rtl/sram_pkg.sv
// Shared constants and types for the SRAM read sequencer.
// Analog rail levels are modelled as reals; the state enum is shared with the bench.
package sram_pkg;

    localparam real VDD = 1.5;
    localparam real VSS = 0.0;
    localparam real VTH = 0.8;

    // Wide enough for the largest legal settle time (15).
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        PRECH,
        WL,
        DONE
    } rd_state_t;

    // Sense amplifier decision for one column.
    function automatic logic sense_bit(input real v);
        return (v >= VTH);
    endfunction

endpackage

// File: rtl/sram_rd_ctrl.sv
// Read sequencer around the SRAM sense amplifier: precharge, drive one wordline
// for SETTLE cycles, capture the sensed word and return it over valid/ready.
module sram_rd_ctrl
    import sram_pkg::*;
#(
    parameter int ROWS   = 16,
    parameter int COLS   = 8,
    parameter int SETTLE = 2,
    localparam int AW    = $clog2(ROWS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rd_req,
    input  logic [AW-1:0]   rd_addr,
    output logic            rd_ready,
    output logic            pre_en,
    output real             row_rd [0:ROWS-1],
    input  real             preout [0:COLS-1],
    output logic [COLS-1:0] rd_data,
    output logic            rd_err,
    output logic            rd_valid,
    input  logic            rd_rready
);

    rd_state_t          r_state;
    rd_state_t          w_next_state;
    logic [AW-1:0]      r_addr_q;
    logic               r_err_q;
    logic [CNT_W-1:0]   r_cnt;
    logic [COLS-1:0]    r_data;
    logic               r_rd_err;
    logic               w_accept;
    logic               w_capture;
    logic               w_addr_err;
    logic [COLS-1:0]    w_sense;

    assign w_addr_err = (32'(rd_addr) >= 32'(ROWS));

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            IDLE: begin
                if (rd_req) begin
                    w_next_state = PRECH;
                    w_accept     = 1'b1;
                end
            end
            PRECH: w_next_state = WL;
            WL: begin
                if (r_cnt == '0) begin
                    w_next_state = DONE;
                    w_capture    = 1'b1;
                end
            end
            DONE: begin
                if (rd_rready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Request context is latched only on accept; rd_addr is don't-care afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr_q <= '0;
            r_err_q  <= 1'b0;
        end else if (w_accept) begin
            r_addr_q <= rd_addr;
            r_err_q  <= w_addr_err;
        end
    end

    // Loaded during PRECH so WL starts with SETTLE-1 and captures when it reaches zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == PRECH) begin
            r_cnt <= CNT_W'(SETTLE - 1);
        end else if (r_state == WL && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    always_comb begin
        w_sense = '0;
        for (int c = 0; c < COLS; c++) begin
            w_sense[c] = sense_bit(preout[c]);
        end
    end

    // preout is only looked at on the capture edge; the response holds until the next capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data   <= '0;
            r_rd_err <= 1'b0;
        end else if (w_capture) begin
            r_data   <= r_err_q ? '0 : w_sense;
            r_rd_err <= r_err_q;
        end
    end

    assign rd_data  = r_data;
    assign rd_err   = r_rd_err;
    assign rd_ready = (r_state == IDLE);
    assign pre_en   = (r_state == PRECH);
    assign rd_valid = (r_state == DONE);

    // Decoded from registered state, so reset drops the wordline without a clock edge.
    always_comb begin
        for (int i = 0; i < ROWS; i++) begin
            row_rd[i] = (r_state == WL && !r_err_q && r_addr_q == AW'(i)) ? VDD : VSS;
        end
    end

endmodule
